// File: rtl/square_period_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : square_period_detector_pkg
//  Description : Shared types and constants for the square-tone measurement
//                path: the signed sample type, the detector state encoding
//                and the default slicer hysteresis.
//  Revision    : 1.0 - initial release
// ============================================================================
package square_period_detector_pkg;

    // One audio sample as produced by the square generator (+7 / -8 levels).
    typedef logic signed [7:0] sample_t;

    // Detector state: IDLE waits for the first rising edge, MEASURE counts.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } det_state_t;

    // Default slicer threshold magnitude.
    localparam int c_HYST_DEFAULT = 2;

endpackage : square_period_detector_pkg
`default_nettype wire

// File: rtl/square_period_detector_hysteresis_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : square_period_detector_hysteresis_slicer
//  Description : Hysteresis slicer. Turns the signed sample stream into a
//                one-bit level and flags level transitions on the current
//                step sample.
//  Ports       : clk_in  - system clock
//                rst_in  - synchronous active-high reset (level -> low)
//                step_in - sample strobe, amp_in valid when high
//                amp_in  - signed sample
//                rise    - current sample moves the level 0 -> 1 (step only)
//                fall    - current sample moves the level 1 -> 0 (step only)
//  Revision    : 1.0 - initial release
// ============================================================================
module square_period_detector_hysteresis_slicer
    import square_period_detector_pkg::*;
#(
    parameter int HYST = c_HYST_DEFAULT
)
(
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    step_in,
    input  sample_t amp_in,
    output logic    rise,
    output logic    fall
);

    // Thresholds held in the sample type so the comparisons stay signed
    // and width-matched.
    localparam sample_t c_THRESH_HI = sample_t'(HYST);
    localparam sample_t c_THRESH_LO = sample_t'(-HYST);

    logic r_level;
    logic w_decision;

    // Samples strictly between the thresholds keep the previous level.
    always_comb begin
        w_decision = r_level;
        if (amp_in >= c_THRESH_HI) begin
            w_decision = 1'b1;
        end else if (amp_in <= c_THRESH_LO) begin
            w_decision = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_level <= 1'b0;
        end else if (step_in) begin
            r_level <= w_decision;
        end
    end

    // Edges are combinational so the top level acts on the same step sample.
    assign rise = step_in &  w_decision & ~r_level;
    assign fall = step_in & ~w_decision &  r_level;

endmodule : square_period_detector_hysteresis_slicer
`default_nettype wire

// File: rtl/square_period_detector.sv
`default_nettype none
// ============================================================================
//  Module      : square_period_detector
//  Description : Recovers period and high time (in step samples) of a square
//                tone using a hysteresis slicer and a rising-edge to
//                rising-edge counter with saturation timeout.
//  Ports       : clk_in      - system clock
//                rst_in      - synchronous active-high reset
//                step_in     - sample strobe
//                amp_in      - signed 8-bit sample
//                period_out  - last measured period
//                high_out    - high phase of the last completed period
//                valid_out   - one-clk pulse when period/high update
//                locked_out  - a full period measured since reset/timeout
//                timeout_out - one-clk pulse on counter saturation
//  Revision    : 1.0 - initial release
// ============================================================================
module square_period_detector
    import square_period_detector_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int HYST      = c_HYST_DEFAULT
)
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 step_in,
    input  sample_t              amp_in,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [CNT_WIDTH-1:0] high_out,
    output logic                 valid_out,
    output logic                 locked_out,
    output logic                 timeout_out
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    det_state_t r_state;
    det_state_t w_state_next;

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_high_latch;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_high;
    logic                 r_valid;
    logic                 r_locked;
    logic                 r_timeout;

    logic w_rise;
    logic w_fall;
    logic w_at_max;
    logic w_count_clear;
    logic w_count_inc;
    logic w_period_load;
    logic w_high_load;
    logic w_timeout;

    square_period_detector_hysteresis_slicer #(
        .HYST (HYST)
    ) u_slicer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .step_in (step_in),
        .amp_in  (amp_in),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_at_max = (r_count == c_CNT_MAX);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    // rise/fall are already qualified by step_in; saturation is not, so it
    // is gated here to keep the FSM frozen between strobes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (step_in && w_at_max) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ datapath control
    // Saturation wins over any edge on the same sample, so period_out never
    // has to represent counter+1 overflowing the counter width.
    always_comb begin
        w_count_clear = 1'b0;
        w_count_inc   = 1'b0;
        w_period_load = 1'b0;
        w_high_load   = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            IDLE: begin
                w_count_clear = w_rise;
            end
            MEASURE: begin
                if (step_in) begin
                    if (w_at_max) begin
                        w_timeout     = 1'b1;
                        w_count_clear = 1'b1;
                    end else if (w_rise) begin
                        w_period_load = 1'b1;
                        w_count_clear = 1'b1;
                    end else begin
                        w_count_inc   = 1'b1;
                        w_high_load   = w_fall;
                    end
                end
            end
            default: begin
                w_count_clear = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count      <= '0;
            r_high_latch <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_valid      <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;

            if (w_count_clear) begin
                r_count <= '0;
            end else if (w_count_inc) begin
                r_count <= r_count + 1'b1;
            end

            if (w_high_load) begin
                r_high_latch <= r_count + 1'b1;
            end

            // high_out is taken from the latch in the same cycle as period_out
            // so the reported pair always belongs to one period.
            if (w_period_load) begin
                r_period <= r_count + 1'b1;
                r_high   <= r_high_latch;
                r_valid  <= 1'b1;
                r_locked <= 1'b1;
            end

            if (w_timeout) begin
                r_timeout <= 1'b1;
                r_locked  <= 1'b0;
            end
        end
    end

    assign period_out  = r_period;
    assign high_out    = r_high;
    assign valid_out   = r_valid;
    assign locked_out  = r_locked;
    assign timeout_out = r_timeout;

endmodule : square_period_detector
`default_nettype wire

// File: tb/tb_square_period_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_square_period_detector
//  Description : Directed, table-driven bench for square_period_detector.
//                A 16-bit instance covers the streaming cases; an 8-bit
//                instance fed the same inputs covers counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_square_period_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic [7:0]  amp;

    logic [15:0] period16, high16;
    logic        valid16, locked16, timeout16;
    logic [7:0]  period8, high8;
    logic        valid8, locked8, timeout8;

    always #5 clk = ~clk;

    square_period_detector #(.CNT_WIDTH(16), .HYST(2)) dut16 (
        .clk_in      (clk),
        .rst_in      (rst),
        .step_in     (step),
        .amp_in      (amp),
        .period_out  (period16),
        .high_out    (high16),
        .valid_out   (valid16),
        .locked_out  (locked16),
        .timeout_out (timeout16)
    );

    square_period_detector #(.CNT_WIDTH(8), .HYST(2)) dut8 (
        .clk_in      (clk),
        .rst_in      (rst),
        .step_in     (step),
        .amp_in      (amp),
        .period_out  (period8),
        .high_out    (high8),
        .valid_out   (valid8),
        .locked_out  (locked8),
        .timeout_out (timeout8)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int gap_lo = 3;
    int gap_hi = 3;

    // One square period: hi samples of +7 then lo samples of -8, optionally
    // with +/-1 noise injected. Expectations apply at the rising-edge sample.
    typedef struct {
        int hi;
        int lo;
        bit noise;
        bit exp_valid;
        int exp_period;
        int exp_high;
        bit exp_locked;
    } seg_t;

    seg_t vec[10];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; outputs may be read right after return.
    task automatic send(input int a);
        int g;
        g = int'($urandom_range(gap_hi, gap_lo));
        step = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        amp  = a[7:0];
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    function automatic int amp_of(input bit hi, input bit noise, input int i);
        if (noise && (i % 5 == 2)) return -1;
        if (noise && (i % 5 == 3)) return 1;
        return hi ? 7 : -8;
    endfunction

    task automatic apply_seg(input int idx);
        seg_t s;
        int   extra;
        s     = vec[idx];
        extra = 0;
        for (int i = 0; i < s.hi; i++) begin
            send(amp_of(1'b1, s.noise, i));
            if (i == 0) begin
                check($sformatf("seg%0d.valid", idx),  valid16,  s.exp_valid);
                check($sformatf("seg%0d.period", idx), period16, s.exp_period);
                check($sformatf("seg%0d.high", idx),   high16,   s.exp_high);
                check($sformatf("seg%0d.locked", idx), locked16, s.exp_locked);
            end else begin
                extra += int'(valid16);
            end
            extra += int'(timeout16);
        end
        for (int i = 0; i < s.lo; i++) begin
            send(amp_of(1'b0, s.noise, i));
            extra += int'(valid16) + int'(timeout16);
        end
        check($sformatf("seg%0d.extra_pulses", idx), extra, 0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        step = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".period"},  period16,  0);
        check({tag, ".high"},    high16,    0);
        check({tag, ".valid"},   valid16,   0);
        check({tag, ".locked"},  locked16,  0);
        check({tag, ".timeout"}, timeout16, 0);
    endtask

    initial begin
        int got;

        //             hi  lo  noise valid period high locked
        vec[0] = '{32, 32, 1'b0, 1'b0,  0,  0, 1'b0};  // first edge: arm only
        vec[1] = '{32, 32, 1'b0, 1'b1, 64, 32, 1'b1};
        vec[2] = '{32, 32, 1'b0, 1'b1, 64, 32, 1'b1};
        vec[3] = '{32, 10, 1'b0, 1'b1, 64, 32, 1'b1};  // transitional period
        vec[4] = '{10, 10, 1'b0, 1'b1, 42, 32, 1'b1};
        vec[5] = '{10, 10, 1'b0, 1'b1, 20, 10, 1'b1};
        vec[6] = '{20, 20, 1'b1, 1'b1, 20, 10, 1'b1};  // noisy period 40
        vec[7] = '{20, 20, 1'b1, 1'b1, 40, 20, 1'b1};
        vec[8] = '{20, 20, 1'b1, 1'b1, 40, 20, 1'b1};
        vec[9] = '{20, 20, 1'b0, 1'b1, 40, 20, 1'b1};

        rst  = 1'b1;
        step = 1'b0;
        amp  = 8'd0;
        @(posedge clk);
        #1;
        do_reset();
        check_reset_state("reset");

        // Steady tone, tone change, noise inside the hysteresis band.
        for (int k = 0; k < 10; k++) apply_seg(k);

        // Same stream with random idle clocks between strobes.
        do_reset();
        gap_lo = 0;
        gap_hi = 5;
        for (int k = 0; k < 5; k++) apply_seg(k);
        gap_lo = 3;
        gap_hi = 3;

        // Saturation timeout on the 8-bit instance.
        do_reset();
        apply_seg(0);
        apply_seg(1);
        send(7);
        check("to.edge_valid8", valid8, 1);
        check("to.edge_period8", period8, 64);
        // The edge sample clears the counter, so the counter reads 255
        // (all ones) on the 256th sample after the edge.
        got = 0;
        for (int n = 1; n <= 300; n++) begin
            send(7);
            if (timeout8) begin
                got = n;
                break;
            end
        end
        check("to.steps_after_edge", got, 256);
        check("to.locked8", locked8, 0);
        check("to.period8_kept", period8, 64);
        check("to.high8_kept", high8, 32);
        check("to.locked16", locked16, 1);
        @(posedge clk);
        #1;
        check("to.pulse_width", timeout8, 0);
        for (int n = 0; n < 5; n++) send(-8);
        send(7);
        check("to.rearm_valid8", valid8, 0);
        check("to.rearm_locked8", locked8, 0);
        check("to.long_valid16", valid16, 1);
        check("to.long_period16", period16, 262);
        check("to.long_high16", high16, 257);

        // Reset in the middle of a period.
        do_reset();
        apply_seg(0);
        apply_seg(1);
        for (int n = 0; n < 10; n++) send(7);
        do_reset();
        check_reset_state("midrst");
        apply_seg(0);
        apply_seg(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_square_period_detector
`default_nettype wire
